bcd_scan_display: RTL
=====================

# bcd_scan_display

Time-multiplexed seven-segment driver that consumes the three 4-bit BCD digits (ones, tens, hundreds) produced by the binary-to-BCD converter and drives a common-anode three-digit display. It captures a new value on a load strobe, commits it only at a frame boundary so no frame ever mixes old and new digits, and applies optional leading-zero blanking. It sits between the BCD conversion stage and the board's segment/anode pins.

## Interface

- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bcd_ones  in  4  ones digit from the BCD converter.
- bcd_tens  in  4  tens digit.
- bcd_hund  in  4  hundreds digit.
- load  in  1  one-cycle strobe; captures all three digits.
- blank_lz  in  1  1 = leading-zero blanking enabled; sampled live every cycle.
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an_n  out  3  active-low digit enables: bit0 = ones, bit1 = tens, bit2 = hundreds.
- digit_idx  out  2  currently driven digit (0 = ones, 1 = tens, 2 = hundreds).
- updated  out  1  one-cycle pulse when the displayed value changes.

## Operation

- Prescaler counts 0 to SCAN_DIV-1 and then wraps to 0. tick = (count == SCAN_DIV-1).
- On tick, idx advances 0→1→2→0. Value 3 is unreachable; if it is ever reached, the next tick forces idx to 0.
- frame_wrap = tick && idx == 2.
- Registers:
  - disp[3]: the shown digits.
  - pend[3]: captured digits.
  - pend_v: pending-value flag.
- load, no frame_wrap: pend ← inputs, pend_v ← 1. Later loads before the wrap overwrite pend, so the last load wins.
- frame_wrap with pend_v=1 and no load: disp ← pend, pend_v ← 0, updated pulses.
- frame_wrap and load in the same cycle: disp ← inputs directly, pend_v ← 0, updated pulses. Any older pend is discarded.
- frame_wrap with pend_v=0 and no load: no change, no pulse.
- Decode (active-low gfedcba):
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19
  - 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10
  - codes 10–15 show "E" = 0x06
  - blank = 0x7F
- Blanking when blank_lz=1:
  - hundreds blanked if disp_hund == 0.
  - tens blanked if disp_hund == 0 and disp_tens == 0.
  - ones is never blanked.
  - An invalid code (10–15) is never blanked, and it counts as nonzero for the blanking of lower digits.
- an_n has exactly one bit low: ~(1 << idx).

## Timing

- seg_n, an_n, digit_idx and updated are registered outputs.
- seg_n and an_n are loaded at the same edge that idx changes, using the new idx and the new disp. The driven digit and its segments therefore never disagree for even one cycle.
- Between ticks, seg_n is refreshed every cycle from the current disp and blank_lz. A change to blank_lz appears on seg_n one cycle later.
- load → visible on the display: at the next frame_wrap, i.e. ≤ 3·SCAN_DIV cycles later. updated is high for exactly the one cycle after that edge.
- Reset values:
  - count = 0, idx = 0, disp = {0,0,0}, pend_v = 0.
  - an_n = 3'b110, seg_n = 0x40, digit_idx = 0, updated = 0.
- Reset asserted mid-frame wins over tick, load and frame_wrap in the same cycle. Pending data is lost.
- Inputs on bcd_* are ignored when load=0.

## Test plan

Use SCAN_DIV=4 unless stated otherwise.

1. Reset: hold rst_n low for 2 cycles mid-scan, then release → an_n=110, seg_n=0x40, digit_idx=0, updated=0. The first tick occurs 4 cycles after release.
2. Deferred load: load hund=1, tens=4, ones=7 while idx=0.
   - No seg_n change before the wrap.
   - After the 2→0 wrap, each slot is checked: ones 0x78, tens 0x19, hundreds 0x79.
   - updated pulses exactly once.
3. Leading zeros:
   - With blank_lz=1: value 0,0,5 → hundreds 0x7F, tens 0x7F, ones 0x12. Value 1,0,0 → 0x79, 0x40, 0x40. Value 0,0,0 → only ones shows 0x40.
   - Toggle blank_lz to 0 → blanked slots show 0x40 within 1 cycle.
4. Invalid code: load hund=0, tens=0xC, ones=0xF with blank_lz=1 → hundreds 0x7F, tens 0x06, ones 0x06.
5. Load races:
   - Two loads before a wrap (123 then 456) → only 456 is ever displayed, with one updated pulse.
   - Load on the frame_wrap cycle with a stale pend=789 → the new value is shown at that edge and 789 never appears.
6. Long run: SCAN_DIV=50000, 1M cycles.
   - an_n always has exactly one low bit and rotates 110→101→011.
   - digit_idx never equals 3.
   - Dwell is exactly 50000 cycles per digit.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Three-digit common-anode seven-segment scanner fed by BCD digits.
// New values are held pending and committed only at a frame boundary, so a frame never mixes old and new digits.
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hund,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg_n,
    output logic [2:0] an_n,
    output logic [1:0] digit_idx,
    output logic       updated
);

    localparam int               CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_ERR   = 7'h06;

    // Active-low gfedcba pattern; codes above nine render as "E".
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_ERR;
        endcase
    endfunction

    // Anode enable for a slot; the unreachable slot 3 turns every digit off.
    function automatic logic [2:0] anode_decode(input logic [1:0] slot);
        case (slot)
            2'd0:    anode_decode = 3'b110;
            2'd1:    anode_decode = 3'b101;
            2'd2:    anode_decode = 3'b011;
            default: anode_decode = 3'b111;
        endcase
    endfunction

    logic [CNT_W-1:0] count_r;
    logic [1:0]       idx_r;
    logic [3:0]       disp_ones_r;
    logic [3:0]       disp_tens_r;
    logic [3:0]       disp_hund_r;
    logic [3:0]       pend_ones_r;
    logic [3:0]       pend_tens_r;
    logic [3:0]       pend_hund_r;
    logic             pend_v_r;
    logic [6:0]       seg_n_r;
    logic [2:0]       an_n_r;
    logic [1:0]       digit_idx_r;
    logic             updated_r;

    logic             tick_s;
    logic             frame_wrap_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [1:0]       idx_nxt_s;
    logic [3:0]       disp_ones_nxt_s;
    logic [3:0]       disp_tens_nxt_s;
    logic [3:0]       disp_hund_nxt_s;
    logic [3:0]       pend_ones_nxt_s;
    logic [3:0]       pend_tens_nxt_s;
    logic [3:0]       pend_hund_nxt_s;
    logic             pend_v_nxt_s;
    logic             updated_nxt_s;
    logic [3:0]       slot_digit_s;
    logic             slot_blank_s;
    logic [6:0]       seg_nxt_s;
    logic [2:0]       an_nxt_s;

    assign tick_s       = (count_r == CNT_MAX);
    assign frame_wrap_s = tick_s && (idx_r == 2'd2);

    // Prescaler and digit-slot rotation; a stray slot 3 is forced back to 0.
    always_comb begin
        count_nxt_s = count_r;
        idx_nxt_s   = idx_r;
        if (tick_s) begin
            count_nxt_s = '0;
            if (idx_r >= 2'd2) begin
                idx_nxt_s = 2'd0;
            end else begin
                idx_nxt_s = idx_r + 2'd1;
            end
        end else begin
            count_nxt_s = count_r + 1'b1;
        end
    end

    // Pending/commit handling: a load coinciding with the wrap bypasses pend.
    always_comb begin
        disp_ones_nxt_s = disp_ones_r;
        disp_tens_nxt_s = disp_tens_r;
        disp_hund_nxt_s = disp_hund_r;
        pend_ones_nxt_s = pend_ones_r;
        pend_tens_nxt_s = pend_tens_r;
        pend_hund_nxt_s = pend_hund_r;
        pend_v_nxt_s    = pend_v_r;
        updated_nxt_s   = 1'b0;
        if (frame_wrap_s) begin
            pend_v_nxt_s = 1'b0;
            if (load) begin
                disp_ones_nxt_s = bcd_ones;
                disp_tens_nxt_s = bcd_tens;
                disp_hund_nxt_s = bcd_hund;
                updated_nxt_s   = 1'b1;
            end else if (pend_v_r) begin
                disp_ones_nxt_s = pend_ones_r;
                disp_tens_nxt_s = pend_tens_r;
                disp_hund_nxt_s = pend_hund_r;
                updated_nxt_s   = 1'b1;
            end else begin
                updated_nxt_s   = 1'b0;
            end
        end else if (load) begin
            pend_ones_nxt_s = bcd_ones;
            pend_tens_nxt_s = bcd_tens;
            pend_hund_nxt_s = bcd_hund;
            pend_v_nxt_s    = 1'b1;
        end else begin
            pend_v_nxt_s    = pend_v_r;
        end
    end

    // Segment/anode lookahead from the next slot and next display value,
    // so the registered anode and segment outputs always change together.
    always_comb begin
        slot_digit_s = disp_ones_nxt_s;
        slot_blank_s = 1'b0;
        case (idx_nxt_s)
            2'd0: begin
                slot_digit_s = disp_ones_nxt_s;
                slot_blank_s = 1'b0;
            end
            2'd1: begin
                slot_digit_s = disp_tens_nxt_s;
                slot_blank_s = blank_lz && (disp_hund_nxt_s == 4'd0) && (disp_tens_nxt_s == 4'd0);
            end
            2'd2: begin
                slot_digit_s = disp_hund_nxt_s;
                slot_blank_s = blank_lz && (disp_hund_nxt_s == 4'd0);
            end
            default: begin
                slot_digit_s = disp_ones_nxt_s;
                slot_blank_s = 1'b0;
            end
        endcase
        if (slot_blank_s) begin
            seg_nxt_s = SEG_BLANK;
        end else begin
            seg_nxt_s = seg_decode(slot_digit_s);
        end
        an_nxt_s = anode_decode(idx_nxt_s);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r     <= '0;
            idx_r       <= 2'd0;
            disp_ones_r <= 4'd0;
            disp_tens_r <= 4'd0;
            disp_hund_r <= 4'd0;
            pend_ones_r <= 4'd0;
            pend_tens_r <= 4'd0;
            pend_hund_r <= 4'd0;
            pend_v_r    <= 1'b0;
            seg_n_r     <= 7'h40;
            an_n_r      <= 3'b110;
            digit_idx_r <= 2'd0;
            updated_r   <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            idx_r       <= idx_nxt_s;
            disp_ones_r <= disp_ones_nxt_s;
            disp_tens_r <= disp_tens_nxt_s;
            disp_hund_r <= disp_hund_nxt_s;
            pend_ones_r <= pend_ones_nxt_s;
            pend_tens_r <= pend_tens_nxt_s;
            pend_hund_r <= pend_hund_nxt_s;
            pend_v_r    <= pend_v_nxt_s;
            seg_n_r     <= seg_nxt_s;
            an_n_r      <= an_nxt_s;
            digit_idx_r <= idx_nxt_s;
            updated_r   <= updated_nxt_s;
        end
    end

    assign seg_n     = seg_n_r;
    assign an_n      = an_n_r;
    assign digit_idx = digit_idx_r;
    assign updated   = updated_r;

endmodule
